// File: rtl/mem_access_unit.sv
// Sequential memory access unit: one request at a time, drives p_ram/v_ram with a registered
// strobe and returns a one-cycle response. Optional one-entry PEEK/FETCH buffer: MEM_ACCESS_PEEK_BUFFER_EN.
module mem_access_unit #(
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned READ_LATENCY  = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_op,
  input  logic [ADDRESS_WIDTH-1:0] pc_address,
  input  logic [ADDRESS_WIDTH-1:0] req_address,
  input  logic [DATA_WIDTH-1:0]    req_data,
  output logic                     resp_valid,
  output logic [DATA_WIDTH-1:0]    resp_data,
  output logic                     resp_error,
  output logic                     p_ram_en,
  output logic                     p_ram_rw,
  output logic [ADDRESS_WIDTH-1:0] p_ram_address,
  output logic [DATA_WIDTH-1:0]    p_ram_wdata,
  input  logic [DATA_WIDTH-1:0]    p_ram_rdata,
  output logic                     v_ram_en,
  output logic                     v_ram_rw,
  output logic [ADDRESS_WIDTH-1:0] v_ram_address,
  output logic [DATA_WIDTH-1:0]    v_ram_wdata,
  input  logic [DATA_WIDTH-1:0]    v_ram_rdata
);

  typedef enum logic [1:0] {StIdle, StAccess, StWait, StResp} state_e;

  localparam logic [2:0] OpFetch  = 3'd0;
  localparam logic [2:0] OpLoad   = 3'd1;
  localparam logic [2:0] OpStore  = 3'd2;
  localparam logic [2:0] OpLoadV  = 3'd3;
  localparam logic [2:0] OpStoreV = 3'd4;
  localparam logic [2:0] OpPeek   = 3'd5;

  localparam logic [2:0] CntInit = 3'(READ_LATENCY - 1);
  localparam logic [ADDRESS_WIDTH-1:0] AddrOne = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

  state_e                   state_q, state_d;
  logic [2:0]               cnt_q, cnt_d;
  logic                     write_q, write_d;
  logic                     sel_v_q, sel_v_d;
  logic                     p_en_q, p_en_d, p_rw_q, p_rw_d;
  logic [ADDRESS_WIDTH-1:0] p_addr_q, p_addr_d;
  logic [DATA_WIDTH-1:0]    p_wdata_q, p_wdata_d;
  logic                     v_en_q, v_en_d, v_rw_q, v_rw_d;
  logic [ADDRESS_WIDTH-1:0] v_addr_q, v_addr_d;
  logic [DATA_WIDTH-1:0]    v_wdata_q, v_wdata_d;
  logic                     resp_valid_q, resp_valid_d;
  logic                     resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0]    resp_data_q, resp_data_d;

  // Request decode, only meaningful while idle
  logic                     op_legal, op_write, op_vram, op_pcread, buf_hit;
  logic [ADDRESS_WIDTH-1:0] eff_addr;

  assign op_legal  = (req_op <= OpPeek);
  assign op_write  = (req_op == OpStore) || (req_op == OpStoreV);
  assign op_vram   = (req_op == OpLoadV) || (req_op == OpStoreV);
  assign op_pcread = (req_op == OpFetch) || (req_op == OpPeek);

  always_comb begin
    eff_addr = req_address;
    if (req_op == OpFetch) eff_addr = pc_address;
    else if (req_op == OpPeek) eff_addr = pc_address + AddrOne;
  end

`ifdef MEM_ACCESS_PEEK_BUFFER_EN
  logic                     buf_valid_q, buf_valid_d;
  logic [ADDRESS_WIDTH-1:0] buf_addr_q, buf_addr_d;
  logic [DATA_WIDTH-1:0]    buf_data_q, buf_data_d;
  logic                     fill_q, fill_d;

  assign buf_hit = op_pcread && buf_valid_q && (buf_addr_q == eff_addr);
`else
  assign buf_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    sel_v_d      = sel_v_q;
    p_en_d       = 1'b0;
    p_rw_d       = p_rw_q;
    p_addr_d     = p_addr_q;
    p_wdata_d    = p_wdata_q;
    v_en_d       = 1'b0;
    v_rw_d       = v_rw_q;
    v_addr_d     = v_addr_q;
    v_wdata_d    = v_wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_data_d  = '0;
`ifdef MEM_ACCESS_PEEK_BUFFER_EN
    buf_valid_d  = buf_valid_q;
    buf_addr_d   = buf_addr_q;
    buf_data_d   = buf_data_q;
    fill_d       = fill_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (!op_legal) begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (buf_hit) begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
`ifdef MEM_ACCESS_PEEK_BUFFER_EN
            resp_data_d  = buf_data_q;
`endif
          end else begin
            state_d = StAccess;
            write_d = op_write;
            sel_v_d = op_vram;
            if (op_vram) begin
              v_en_d    = 1'b1;
              v_rw_d    = op_write;
              v_addr_d  = eff_addr;
              v_wdata_d = req_data;
            end else begin
              p_en_d    = 1'b1;
              p_rw_d    = op_write;
              p_addr_d  = eff_addr;
              p_wdata_d = req_data;
            end
`ifdef MEM_ACCESS_PEEK_BUFFER_EN
            fill_d = op_pcread;
            if (op_write) buf_valid_d = 1'b0;
`endif
          end
        end
      end
      StAccess: begin
        if (write_q) begin
          state_d      = StResp;
          resp_valid_d = 1'b1;
        end else begin
          state_d = StWait;
          cnt_d   = CntInit;
        end
      end
      StWait: begin
        if (cnt_q == 3'd0) begin
          state_d      = StResp;
          resp_valid_d = 1'b1;
          resp_data_d  = sel_v_q ? v_ram_rdata : p_ram_rdata;
`ifdef MEM_ACCESS_PEEK_BUFFER_EN
          if (fill_q) begin
            buf_valid_d = 1'b1;
            buf_addr_d  = p_addr_q;
            buf_data_d  = p_ram_rdata;
          end
`endif
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      sel_v_q      <= 1'b0;
      p_en_q       <= 1'b0;
      p_rw_q       <= 1'b0;
      p_addr_q     <= '0;
      p_wdata_q    <= '0;
      v_en_q       <= 1'b0;
      v_rw_q       <= 1'b0;
      v_addr_q     <= '0;
      v_wdata_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      sel_v_q      <= sel_v_d;
      p_en_q       <= p_en_d;
      p_rw_q       <= p_rw_d;
      p_addr_q     <= p_addr_d;
      p_wdata_q    <= p_wdata_d;
      v_en_q       <= v_en_d;
      v_rw_q       <= v_rw_d;
      v_addr_q     <= v_addr_d;
      v_wdata_q    <= v_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_data_q  <= resp_data_d;
    end
  end

`ifdef MEM_ACCESS_PEEK_BUFFER_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      fill_q      <= 1'b0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      fill_q      <= fill_d;
    end
  end
`endif

  assign req_ready     = (state_q == StIdle);
  assign resp_valid    = resp_valid_q;
  assign resp_error    = resp_err_q;
  assign resp_data     = resp_data_q;
  assign p_ram_en      = p_en_q;
  assign p_ram_rw      = p_rw_q;
  assign p_ram_address = p_addr_q;
  assign p_ram_wdata   = p_wdata_q;
  assign v_ram_en      = v_en_q;
  assign v_ram_rw      = v_rw_q;
  assign v_ram_address = v_addr_q;
  assign v_ram_wdata   = v_wdata_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sequential, parametrised successor to the combinational load/store decoder.
- Accepts one microcode memory request at a time over a valid/ready handshake.
- Drives the program RAM (p_ram) and variable RAM (v_ram) ports with a single-cycle enable strobe, waits a configurable synchronous read latency, and returns read data or a write acknowledge on a one-cycle response pulse.
- Sits between the microcode sequencer / register file (regs {E,F} address, {G,H} data) and both RAMs.

Parameters:
ADDRESS_WIDTH, 16, width of all address ports and the program counter.
DATA_WIDTH, 16, width of all data ports.
READ_LATENCY, 1, cycles from RAM enable to valid rdata; legal range 1..8.

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous, active-low reset.
req_valid  input  1  request present.
req_ready  output  1  unit can accept a request this cycle.
req_op  input  3  operation code (see Behaviour).
pc_address  input  ADDRESS_WIDTH  current program counter.
req_address  input  ADDRESS_WIDTH  operand address, regs {E,F}.
req_data  input  DATA_WIDTH  store data, regs {G,H}.
resp_valid  output  1  one-cycle response pulse.
resp_data  output  DATA_WIDTH  read data; 0 for stores and errors.
resp_error  output  1  qualifies resp_valid: illegal op.
p_ram_en  output  1  program RAM access strobe.
p_ram_rw  output  1  1 = write, 0 = read.
p_ram_address  output  ADDRESS_WIDTH  program RAM address.
p_ram_wdata  output  DATA_WIDTH  program RAM write data.
p_ram_rdata  input  DATA_WIDTH  program RAM read data.
v_ram_en, v_ram_rw, v_ram_address, v_ram_wdata, v_ram_rdata: same widths and meanings as the p_ram ports, for the variable RAM.

Behaviour:
- Asynchronous, active-low reset; one clock.
- Ops:
  - 0 FETCH: p read at pc_address.
  - 1 LOAD: p read at req_address.
  - 2 STORE: p write req_data to req_address.
  - 3 LOADV: v read at req_address.
  - 4 STOREV: v write req_data to req_address.
  - 5 PEEK: p read at pc_address+1, computed modulo 2^ADDRESS_WIDTH (all-ones wraps to 0).
  - 6, 7: illegal.
- Reset: state IDLE. All outputs 0 except req_ready = 1. Reset asserted mid-operation aborts it immediately; RAM strobes drop asynchronously and no response is issued.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready (cycle T), latch op, address and data.
  - Legal op -> ACCESS. Illegal op -> RESP with resp_error set.
- ACCESS (T+1):
  - Exactly one of p_ram_en / v_ram_en is high for one cycle, with rw, address and wdata valid.
  - Write -> RESP. Read -> WAIT.
- WAIT:
  - Down-counter loaded with READ_LATENCY-1.
  - At count 0, rdata of the selected RAM is registered (the cycle T+1+READ_LATENCY) -> RESP.
- RESP:
  - resp_valid = 1 for exactly one cycle. Reads return captured data; writes and errors return 0.
  - -> IDLE.
- Latencies: read response at T+2+READ_LATENCY; write response at T+2; illegal-op response at T+1.
- req_ready = 0 in every state except IDLE. The sequencer must hold the request until accepted. No back-to-back acceptance: minimum accept spacing is 3 cycles for writes.
- RAM outputs are registered. Address, wdata and rw hold their last values while en = 0; en is the only qualifier.
- Inputs are ignored outside IDLE.

Optional Feature:
- Macro: MEM_ACCESS_PEEK_BUFFER_EN.
- When defined:
  - A one-entry buffer {valid, address, data} is filled on every completed PEEK or FETCH read.
  - A PEEK or FETCH whose effective address matches a valid entry skips ACCESS/WAIT and responds at T+1 from the buffer, with no RAM strobe.
  - Any STORE invalidates the entry; so does reset.
- When not defined: no buffer logic; every read accesses RAM.

Test Plan:
1. READ_LATENCY=2: write 0xBEEF to p_ram[0x0010] via STORE -> p_ram_en one cycle at T+1 with rw=1, addr 0x0010, wdata 0xBEEF; resp_valid at T+2, resp_data 0.
2. LOAD 0x0010 with model RAM returning 0xBEEF -> p_ram_en at T+1 rw=0; resp_valid at T+4, resp_data 0xBEEF; req_ready 0 from T+1 to T+4.
3. STOREV 0x1234 at 0x0003, then LOADV 0x0003 -> only v_ram_en pulses, p_ram_en stays 0; read returns 0x1234.
4. PEEK with pc_address 0xFFFF -> p_ram_address 0x0000; op 6 -> resp_valid at T+1 with resp_error 1, no RAM strobe.
5. Assert reset_n low in WAIT of a LOAD -> en, resp_valid 0 immediately, req_ready 1 after release, no stale response.
6. With MEM_ACCESS_PEEK_BUFFER_EN, PEEK pc 0x0040 twice -> second returns at T+1 with no strobe; after STORE to any address, third PEEK strobes p_ram again.
